// File: rtl/dm_store_controller.sv
// ============================================================================
// dm_store_controller : MEM-stage store path with read-modify-write for sub-DW
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module dm_store_controller #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_mem_wr,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [63:0]       i_mem_data,
    input  logic [1:0]        i_mem_req_unit,
    output logic              o_ready,
    output logic              o_staller,
    output logic              o_miss_aligned_error,
    output logic              o_done,
    output logic [ADDR_W-4:0] dm_addr,
    output logic              dm_rd_en,
    input  logic [63:0]       dm_rd_data,
    input  logic              dm_rd_valid,
    output logic              dm_wr_en,
    output logic [63:0]       dm_wr_data
);

    localparam logic [1:0] c_UNIT_B  = 2'b00;
    localparam logic [1:0] c_UNIT_HW = 2'b01;
    localparam logic [1:0] c_UNIT_W  = 2'b10;
    localparam logic [1:0] c_UNIT_DW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WRITE   = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    state_t            r_state;
    logic [2:0]        r_off;
    logic [1:0]        r_unit;
    logic [63:0]       r_data;
    logic [ADDR_W-4:0] r_dm_addr;
    logic              r_rd_en;
    logic              r_wr_en;
    logic              r_done;
    logic              r_err;
    logic [63:0]       r_wr_data;

    logic              w_accept;
    logic              w_misaligned;
    logic [63:0]       w_lane_mask;
    logic [63:0]       w_mask;
    logic [63:0]       w_merged;

    assign w_accept = (r_state == S_IDLE) && i_valid && i_mem_wr;

    always_comb begin
        w_misaligned = 1'b0;
        case (i_mem_req_unit)
            c_UNIT_HW: w_misaligned = (i_mem_addr[2:0] == 3'd7);
            c_UNIT_W:  w_misaligned = (i_mem_addr[2:0] >= 3'd5);
            c_UNIT_DW: w_misaligned = (i_mem_addr[2:0] != 3'd0);
            default:   w_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        w_lane_mask = 64'h0000_0000_FFFF_FFFF;
        case (r_unit)
            c_UNIT_B:  w_lane_mask = 64'h0000_0000_0000_00FF;
            c_UNIT_HW: w_lane_mask = 64'h0000_0000_0000_FFFF;
            default:   w_lane_mask = 64'h0000_0000_FFFF_FFFF;
        endcase
    end

    // Mask confines the shifted store data, so upper bits beyond the unit drop out.
    assign w_mask   = w_lane_mask << {r_off, 3'b000};
    assign w_merged = (dm_rd_data & ~w_mask) | ((r_data << {r_off, 3'b000}) & w_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_off     <= 3'd0;
            r_unit    <= 2'd0;
            r_data    <= 64'd0;
            r_dm_addr <= '0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wr_data <= 64'd0;
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_off     <= i_mem_addr[2:0];
                        r_unit    <= i_mem_req_unit;
                        r_data    <= i_mem_data;
                        r_dm_addr <= i_mem_addr[ADDR_W-1:3];
                        if (w_misaligned) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else if (i_mem_req_unit == c_UNIT_DW) begin
                            r_state   <= S_WRITE;
                            r_wr_en   <= 1'b1;
                            r_done    <= 1'b1;
                            r_wr_data <= i_mem_data;
                        end else begin
                            r_state <= S_RD;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (dm_rd_valid) begin
                        r_state   <= S_WRITE;
                        r_wr_en   <= 1'b1;
                        r_done    <= 1'b1;
                        r_wr_data <= w_merged;
                    end
                end
                S_WRITE, S_ERR: begin
                    r_state   <= S_IDLE;
                    r_dm_addr <= '0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_dm_addr <= '0;
                end
            endcase
        end
    end

    assign o_ready              = (r_state == S_IDLE);
    assign o_staller            = i_valid & i_mem_wr & ~r_done & ~r_err;
    assign o_miss_aligned_error = r_err;
    assign o_done               = r_done;
    assign dm_addr              = r_dm_addr;
    assign dm_rd_en             = r_rd_en;
    assign dm_wr_en             = r_wr_en;
    assign dm_wr_data           = r_wr_data;

endmodule

`default_nettype wire
